// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-side types: fetch state, fault codes, PC redirect-select encoding
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      VALID = 2'd2,
      FAULT = 2'd3
   } fetch_state_e;

   // Redirect-select encoding shared with the PC register.
   typedef enum logic [1:0] {
      SEL_NORMAL = 2'b00,
      SEL_BRANCH = 2'b01,
      SEL_TRAP   = 2'b10,
      SEL_RET    = 2'b11
   } redir_sel_e;

   localparam logic [3:0] FC_INSTR_MISALIGN = 4'd0;
   localparam logic [3:0] FC_INSTR_ACCESS   = 4'd1;

endpackage

// File: rtl/redirect_arb.sv
// rtl/redirect_arb.sv - merges live redirect requests with one pending redirect
//   clk, rst              : clock, async active-high reset
//   *_req / *_tgt         : live branch, trap and return redirects
//   hold                  : capture live requests into the pending register
//   apply                 : effective redirect is consumed; pending register clears
//   eff_valid/sel/tgt     : effective redirect after priority merge
module redirect_arb
   import cpu_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            branch_req,
   input  logic [XLEN-1:0] branch_tgt,
   input  logic            trap_req,
   input  logic [XLEN-1:0] trap_tgt,
   input  logic            ret_req,
   input  logic [XLEN-1:0] ret_tgt,
   input  logic            hold,
   input  logic            apply,
   output logic            eff_valid,
   output redir_sel_e      eff_sel,
   output logic [XLEN-1:0] eff_tgt
);

   // SEL_NORMAL in the pending select means the register is empty.
   redir_sel_e      pend_sel_q, pend_sel_d;
   logic [XLEN-1:0] pend_tgt_q, pend_tgt_d;

   // Traps (live or pending) dominate; a live branch/ret beats an older pending one.
   always_comb begin
      eff_valid = 1'b1;
      eff_sel   = SEL_NORMAL;
      eff_tgt   = '0;
      if (trap_req) begin
         eff_sel = SEL_TRAP;
         eff_tgt = trap_tgt;
      end else if (pend_sel_q == SEL_TRAP) begin
         eff_sel = pend_sel_q;
         eff_tgt = pend_tgt_q;
      end else if (branch_req) begin
         eff_sel = SEL_BRANCH;
         eff_tgt = branch_tgt;
      end else if (ret_req) begin
         eff_sel = SEL_RET;
         eff_tgt = ret_tgt;
      end else if (pend_sel_q != SEL_NORMAL) begin
         eff_sel = pend_sel_q;
         eff_tgt = pend_tgt_q;
      end else begin
         eff_valid = 1'b0;
      end
   end

   always_comb begin
      pend_sel_d = pend_sel_q;
      pend_tgt_d = pend_tgt_q;
      if (apply) begin
         pend_sel_d = SEL_NORMAL;
         pend_tgt_d = '0;
      end else if (hold) begin
         if (trap_req) begin
            pend_sel_d = SEL_TRAP;
            pend_tgt_d = trap_tgt;
         end else if (pend_sel_q != SEL_TRAP) begin
            if (branch_req) begin
               pend_sel_d = SEL_BRANCH;
               pend_tgt_d = branch_tgt;
            end else if (ret_req) begin
               pend_sel_d = SEL_RET;
               pend_tgt_d = ret_tgt;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_sel_q <= SEL_NORMAL;
         pend_tgt_q <= '0;
      end else begin
         pend_sel_q <= pend_sel_d;
         pend_tgt_q <= pend_tgt_d;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer around the PC register
//   pc_addr/pc_misaligned : current PC and its alignment flag
//   pc_en, pc_*_taken/pc_*: PC update strobe, one-hot redirect select and targets
//   *_req/*_tgt           : redirect requests from execute/CSR
//   imem_*                : instruction memory request/ack
//   instr_valid/instr/instr_pc/stall : decode handshake
//   fetch_fault/fault_code/fault_pc  : pending fetch exception
module fetch_ctrl
   import cpu_pkg::*;
#(
   parameter int XLEN        = 64,
   parameter int ILEN        = 32,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_addr,
   input  logic            pc_misaligned,
   output logic            pc_en,
   output logic            pc_branch_taken,
   output logic            pc_trap_taken,
   output logic            pc_ret_taken,
   output logic [XLEN-1:0] pc_branch,
   output logic [XLEN-1:0] pc_trap,
   output logic [XLEN-1:0] pc_ret,
   input  logic            branch_req,
   input  logic            trap_req,
   input  logic            ret_req,
   input  logic [XLEN-1:0] branch_tgt,
   input  logic [XLEN-1:0] trap_tgt,
   input  logic [XLEN-1:0] ret_tgt,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [ILEN-1:0] imem_rdata,
   output logic            instr_valid,
   output logic [ILEN-1:0] instr,
   output logic [XLEN-1:0] instr_pc,
   input  logic            stall,
   output logic            fetch_fault,
   output logic [3:0]      fault_code,
   output logic [XLEN-1:0] fault_pc
);

   // Counter only needs to reach ACK_TIMEOUT-1: the timeout fires on that cycle.
   localparam int CW = $clog2(ACK_TIMEOUT);

   fetch_state_e    state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [ILEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] instr_pc_q, instr_pc_d;
   logic [3:0]      fault_code_q, fault_code_d;
   logic [XLEN-1:0] fault_pc_q, fault_pc_d;

   logic            redir_hold, redir_apply, seq_en;
   logic            eff_valid;
   redir_sel_e      eff_sel;
   logic [XLEN-1:0] eff_tgt;

   redirect_arb #(.XLEN(XLEN)) u_arb (
      .clk        (clk),
      .rst        (rst),
      .branch_req (branch_req),
      .branch_tgt (branch_tgt),
      .trap_req   (trap_req),
      .trap_tgt   (trap_tgt),
      .ret_req    (ret_req),
      .ret_tgt    (ret_tgt),
      .hold       (redir_hold),
      .apply      (redir_apply),
      .eff_valid  (eff_valid),
      .eff_sel    (eff_sel),
      .eff_tgt    (eff_tgt)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      instr_d      = instr_q;
      instr_pc_d   = instr_pc_q;
      fault_code_d = fault_code_q;
      fault_pc_d   = fault_pc_q;
      imem_req     = 1'b0;
      seq_en       = 1'b0;
      redir_hold   = 1'b0;
      redir_apply  = 1'b0;
      case (state_q)
         IDLE: begin
            redir_hold = 1'b1;
            if (pc_misaligned) begin
               state_d      = FAULT;
               fault_code_d = FC_INSTR_MISALIGN;
               fault_pc_d   = pc_addr;
            end else begin
               state_d = REQ;
               cnt_d   = '0;
            end
         end
         REQ: begin
            if (pc_misaligned) begin
               // Never put a misaligned address on the bus.
               redir_hold   = 1'b1;
               state_d      = FAULT;
               fault_code_d = FC_INSTR_MISALIGN;
               fault_pc_d   = pc_addr;
            end else begin
               imem_req = 1'b1;
               if (imem_ack) begin
                  if (eff_valid) begin
                     // Returned data belongs to the wrong path; refetch at the target.
                     redir_apply = 1'b1;
                     cnt_d       = '0;
                  end else begin
                     instr_d    = imem_rdata;
                     instr_pc_d = pc_addr;
                     seq_en     = 1'b1;
                     state_d    = VALID;
                  end
               end else begin
                  redir_hold = 1'b1;
                  if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
                     state_d      = FAULT;
                     fault_code_d = FC_INSTR_ACCESS;
                     fault_pc_d   = pc_addr;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
         end
         VALID: begin
            if (eff_valid) begin
               redir_apply = 1'b1;
               state_d     = REQ;
               cnt_d       = '0;
            end else if (!stall) begin
               state_d = REQ;
               cnt_d   = '0;
            end
         end
         FAULT: begin
            if (eff_valid) begin
               redir_apply  = 1'b1;
               fault_code_d = '0;
               fault_pc_d   = '0;
               state_d      = REQ;
               cnt_d        = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         instr_q      <= '0;
         instr_pc_q   <= '0;
         fault_code_q <= '0;
         fault_pc_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         instr_q      <= instr_d;
         instr_pc_q   <= instr_pc_d;
         fault_code_q <= fault_code_d;
         fault_pc_q   <= fault_pc_d;
      end
   end

   assign pc_en           = seq_en | redir_apply;
   assign pc_branch_taken = redir_apply && (eff_sel == SEL_BRANCH);
   assign pc_trap_taken   = redir_apply && (eff_sel == SEL_TRAP);
   assign pc_ret_taken    = redir_apply && (eff_sel == SEL_RET);
   assign pc_branch       = pc_branch_taken ? eff_tgt : '0;
   assign pc_trap         = pc_trap_taken   ? eff_tgt : '0;
   assign pc_ret          = pc_ret_taken    ? eff_tgt : '0;

   assign imem_addr   = pc_addr;
   assign instr_valid = (state_q == VALID);
   assign instr       = instr_q;
   assign instr_pc    = instr_pc_q;
   assign fetch_fault = (state_q == FAULT);
   assign fault_code  = fault_code_q;
   assign fault_pc    = fault_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl with a PC register and memory model
module tb_fetch_ctrl;

   localparam int XLEN = 64;
   localparam int ILEN = 32;
   localparam int TO   = 4;

   logic            clk, rst;
   logic [XLEN-1:0] pc_addr;
   logic            pc_misaligned;
   logic            pc_en, pc_branch_taken, pc_trap_taken, pc_ret_taken;
   logic [XLEN-1:0] pc_branch, pc_trap, pc_ret;
   logic            branch_req, trap_req, ret_req;
   logic [XLEN-1:0] branch_tgt, trap_tgt, ret_tgt;
   logic            imem_req, imem_ack;
   logic [XLEN-1:0] imem_addr;
   logic [ILEN-1:0] imem_rdata;
   logic            instr_valid, stall, fetch_fault;
   logic [ILEN-1:0] instr;
   logic [XLEN-1:0] instr_pc, fault_pc;
   logic [3:0]      fault_code;

   int n_tests = 0;
   int n_fail  = 0;

   fetch_ctrl #(.XLEN(XLEN), .ILEN(ILEN), .ACK_TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst), .pc_addr(pc_addr), .pc_misaligned(pc_misaligned),
      .pc_en(pc_en), .pc_branch_taken(pc_branch_taken), .pc_trap_taken(pc_trap_taken),
      .pc_ret_taken(pc_ret_taken), .pc_branch(pc_branch), .pc_trap(pc_trap), .pc_ret(pc_ret),
      .branch_req(branch_req), .trap_req(trap_req), .ret_req(ret_req),
      .branch_tgt(branch_tgt), .trap_tgt(trap_tgt), .ret_tgt(ret_tgt),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc), .stall(stall),
      .fetch_fault(fetch_fault), .fault_code(fault_code), .fault_pc(fault_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Environment PC register: trap > branch > ret, else sequential +4.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                  pc_addr <= '0;
      else if (pc_en) begin
         if (pc_trap_taken)        pc_addr <= pc_trap;
         else if (pc_branch_taken) pc_addr <= pc_branch;
         else if (pc_ret_taken)    pc_addr <= pc_ret;
         else                      pc_addr <= pc_addr + 64'd4;
      end
   end
   assign pc_misaligned = (pc_addr[1:0] != 2'b00);

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Start of a cycle: one-shot inputs drop back to idle.
   task automatic adv();
      @(negedge clk);
      imem_ack   = 1'b0;
      branch_req = 1'b0;
      trap_req   = 1'b0;
      ret_req    = 1'b0;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic drive_redirect(input int kind, input logic [63:0] tgt);
      case (kind)
         0:       begin branch_req = 1'b1; branch_tgt = tgt; end
         1:       begin trap_req   = 1'b1; trap_tgt   = tgt; end
         default: begin ret_req    = 1'b1; ret_tgt    = tgt; end
      endcase
   endtask

   logic [31:0] d1 [3];
   logic [63:0] exp_pc, tgt, tgt2;
   int          lat, rcyc, kind, stalls;
   bit          redir, squash;

   initial begin
      rst = 1'b1; stall = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
      branch_req = 1'b0; trap_req = 1'b0; ret_req = 1'b0;
      branch_tgt = '0; trap_tgt = '0; ret_tgt = '0;
      d1[0] = 32'h13; d1[1] = 32'h93; d1[2] = 32'h113;

      repeat (2) @(negedge clk);
      settle();
      chk("rst_imem_req", imem_req, 0);
      chk("rst_pc_en", pc_en, 0);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_fetch_fault", fetch_fault, 0);

      adv(); rst = 1'b0; settle();
      chk("idle_no_req", imem_req, 0);

      // Sequential fetch with a 3-cycle stall on the second instruction.
      for (int k = 0; k < 3; k++) begin
         adv(); imem_ack = 1'b1; imem_rdata = d1[k]; settle();
         chk("seq_req", imem_req, 1);
         chk("seq_addr", imem_addr, 64'(4 * k));
         chk("seq_pc_en", pc_en, 1);
         chk("seq_sel_none", {pc_branch_taken, pc_trap_taken, pc_ret_taken}, 0);
         for (int s = 0; s < ((k == 1) ? 4 : 1); s++) begin
            adv(); stall = (k == 1) && (s < 3); settle();
            chk("valid", instr_valid, 1);
            chk("valid_instr", instr, d1[k]);
            chk("valid_pc", instr_pc, 64'(4 * k));
            chk("valid_no_pc_en", pc_en, 0);
            chk("valid_no_req", imem_req, 0);
         end
         stall = 1'b0;
      end

      // Pending branch discards the ack data.
      adv(); branch_req = 1'b1; branch_tgt = 64'h100; settle();
      chk("br_latch_no_pc_en", pc_en, 0);
      adv(); settle();
      adv(); imem_ack = 1'b1; imem_rdata = 32'hDEAD; settle();
      chk("br_pc_en", pc_en, 1);
      chk("br_taken", {pc_branch_taken, pc_trap_taken, pc_ret_taken}, 3'b100);
      chk("br_tgt", pc_branch, 64'h100);
      adv(); settle();
      chk("br_discard", instr_valid, 0);
      chk("br_addr", imem_addr, 64'h100);

      // Trap beats live and pending branches.
      adv(); branch_req = 1'b1; branch_tgt = 64'h140; settle();
      adv(); trap_req = 1'b1; trap_tgt = 64'h200; branch_req = 1'b1; branch_tgt = 64'h300;
      imem_ack = 1'b1; settle();
      chk("trap_sel", {pc_branch_taken, pc_trap_taken, pc_ret_taken}, 3'b010);
      chk("trap_tgt", pc_trap, 64'h200);
      // Live branch beats live ret; then a lone ret.
      adv(); ret_req = 1'b1; ret_tgt = 64'h240; branch_req = 1'b1; branch_tgt = 64'h280;
      imem_ack = 1'b1; settle();
      chk("br_over_ret_addr", imem_addr, 64'h200);
      chk("br_over_ret", {pc_branch_taken, pc_trap_taken, pc_ret_taken}, 3'b100);
      chk("br_over_ret_tgt", pc_branch, 64'h280);
      adv(); ret_req = 1'b1; ret_tgt = 64'h40; imem_ack = 1'b1; settle();
      chk("ret_sel", {pc_branch_taken, pc_trap_taken, pc_ret_taken}, 3'b001);
      chk("ret_tgt", pc_ret, 64'h40);

      // Ack timeout.
      for (int c = 0; c < TO; c++) begin
         adv(); settle();
         chk("to_req", imem_req, 1);
         chk("to_addr", imem_addr, 64'h40);
         chk("to_no_fault", fetch_fault, 0);
      end
      adv(); settle();
      chk("to_req_drop", imem_req, 0);
      chk("to_fault", fetch_fault, 1);
      chk("to_code", fault_code, 1);
      chk("to_fault_pc", fault_pc, 64'h40);
      adv(); settle();
      chk("to_hold", fetch_fault, 1);
      chk("to_hold_pc_en", pc_en, 0);
      adv(); trap_req = 1'b1; trap_tgt = 64'h80; settle();
      chk("to_trap_sel", pc_trap_taken, 1);
      chk("to_trap_tgt", pc_trap, 64'h80);
      adv(); settle();
      chk("to_clear_fault", fetch_fault, 0);
      chk("to_clear_code", fault_code, 0);
      chk("to_clear_pc", fault_pc, 0);
      chk("to_resume_addr", imem_addr, 64'h80);
      chk("to_resume_req", imem_req, 1);

      // Branch to a misaligned target.
      adv(); branch_req = 1'b1; branch_tgt = 64'h102; imem_ack = 1'b1; settle();
      chk("mis_branch", pc_branch_taken, 1);
      adv(); settle();
      chk("mis_no_req", imem_req, 0);
      adv(); settle();
      chk("mis_fault", fetch_fault, 1);
      chk("mis_code", fault_code, 0);
      chk("mis_fault_pc", fault_pc, 64'h102);
      adv(); trap_req = 1'b1; trap_tgt = 64'h10; settle();
      chk("mis_trap", pc_trap_taken, 1);
      adv(); settle();
      chk("mis_resume", imem_addr, 64'h10);

      // Pending trap survives a later live branch.
      adv(); trap_req = 1'b1; trap_tgt = 64'h300; settle();
      adv(); branch_req = 1'b1; branch_tgt = 64'h400; settle();
      chk("ptrap_no_pc_en", pc_en, 0);
      adv(); imem_ack = 1'b1; settle();
      chk("ptrap_sel", {pc_branch_taken, pc_trap_taken, pc_ret_taken}, 3'b010);
      chk("ptrap_tgt", pc_trap, 64'h300);

      // Randomized traffic against an address-level model.
      exp_pc = 64'h300;
      for (int n = 0; n < 150; n++) begin
         lat   = $urandom_range(0, 2);
         redir = ($urandom_range(0, 3) == 0);
         rcyc  = $urandom_range(0, lat);
         kind  = $urandom_range(0, 2);
         tgt   = {52'd0, 10'($urandom_range(0, 1023)), 2'b00};
         for (int c = 0; c <= lat; c++) begin
            adv();
            if (c == lat) begin imem_ack = 1'b1; imem_rdata = mem_word(exp_pc); end
            if (redir && c == rcyc) drive_redirect(kind, tgt);
            settle();
            chk("rnd_req", imem_req, 1);
            chk("rnd_addr", imem_addr, exp_pc);
            chk("rnd_pc_en", pc_en, (c == lat));
            if (c == lat) begin
               chk("rnd_sel", {pc_branch_taken, pc_trap_taken, pc_ret_taken},
                   !redir ? 3'b000 : (kind == 0) ? 3'b100 : (kind == 1) ? 3'b010 : 3'b001);
            end
         end
         if (redir) begin
            exp_pc = tgt;
         end else begin
            stalls = $urandom_range(0, 2);
            squash = ($urandom_range(0, 4) == 0);
            tgt2   = {52'd0, 10'($urandom_range(0, 1023)), 2'b00};
            for (int s = 0; s <= stalls; s++) begin
               adv();
               stall = (s < stalls);
               if (squash && s == stalls) drive_redirect(0, tgt2);
               settle();
               chk("rnd_valid", instr_valid, 1);
               chk("rnd_instr", instr, mem_word(exp_pc));
               chk("rnd_instr_pc", instr_pc, exp_pc);
               chk("rnd_valid_pc_en", pc_en, (squash && s == stalls));
               chk("rnd_valid_no_req", imem_req, 0);
            end
            stall  = 1'b0;
            exp_pc = squash ? tgt2 : exp_pc + 64'd4;
         end
      end

      // Asynchronous reset in the middle of a request.
      adv(); settle();
      chk("pre_rst_req", imem_req, 1);
      rst = 1'b1;
      settle();
      chk("arst_req", imem_req, 0);
      chk("arst_pc_en", pc_en, 0);
      chk("arst_valid", instr_valid, 0);
      chk("arst_instr", instr, 0);
      chk("arst_instr_pc", instr_pc, 0);
      chk("arst_fault", fetch_fault, 0);
      chk("arst_fault_pc", fault_pc, 0);
      chk("arst_addr", imem_addr, 0);
      adv(); rst = 1'b0; settle();
      chk("post_rst_idle", imem_req, 0);
      adv(); settle();
      chk("post_rst_req", imem_req, 1);
      chk("post_rst_addr", imem_addr, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
